// File: rtl/axi_bridge_pkg.sv
// Shared AXI3 encodings and the write-strobe helper for the SRAM-to-AXI bridge.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package axi_bridge_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] SIZE_B     = 2'd0;
  localparam logic [1:0] SIZE_H     = 2'd1;
  localparam logic [1:0] SIZE_W     = 2'd2;
  localparam int         AXI_ID_W   = 4;

  // Byte lanes for a single 32-bit beat; sizes above a word collapse to a full word.
  function automatic logic [3:0] wstrb_gen(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  wstrb_gen = 4'b0001 << off;
      SIZE_H:  wstrb_gen = 4'b0011 << off;
      SIZE_W:  wstrb_gen = 4'b1111;
      default: wstrb_gen = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sram_axi_bridge_mc_rr_arbiter.sv
// Round-robin pick of the first eligible requester at or after the rr pointer.
// Latency: combinational.
// Backpressure: none; the caller folds all blocking conditions into elig.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] rr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  always_comb begin : pick
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr) + k) % N;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/sram_axi_bridge_mc.sv
// Multi-channel SRAM-like to AXI3 master bridge: one outstanding txn per channel, AXI ID = channel.
// Latency: addr_ok in grant cycle, AR/AW/W valid next cycle; data_ok combinational from R/B.
// Backpressure: one AR and one write in flight at a time; rready/bready tied high.
module sram_axi_bridge_mc
  import axi_bridge_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        ch_req,
  input  logic [N_CH-1:0]        ch_wr,
  input  logic [2*N_CH-1:0]      ch_size,
  input  logic [LEN_W*N_CH-1:0]  ch_len,
  input  logic [ADDR_W*N_CH-1:0] ch_addr,
  input  logic [32*N_CH-1:0]     ch_wdata,
  output logic [N_CH-1:0]        ch_addr_ok,
  output logic [N_CH-1:0]        ch_data_ok,
  output logic [N_CH-1:0]        ch_last,
  output logic [N_CH-1:0]        ch_err,
  output logic [31:0]            ch_rdata,
  output logic [3:0]             arid,
  output logic [ADDR_W-1:0]      araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic [1:0]             arlock,
  output logic [3:0]             arcache,
  output logic [2:0]             arprot,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [3:0]             rid,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [3:0]             awid,
  output logic [ADDR_W-1:0]      awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic [1:0]             awlock,
  output logic [3:0]             awcache,
  output logic [2:0]             awprot,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [3:0]             wid,
  output logic [31:0]            wdata,
  output logic [3:0]             wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [3:0]             bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [ADDR_W-1:0] req_addr  [N_CH];
  logic [1:0]        req_size  [N_CH];
  logic [LEN_W-1:0]  req_len   [N_CH];
  logic [31:0]       req_wdata [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign req_addr[g]  = ch_addr[g*ADDR_W +: ADDR_W];
    assign req_size[g]  = ch_size[g*2 +: 2];
    assign req_len[g]   = ch_len[g*LEN_W +: LEN_W];
    assign req_wdata[g] = ch_wdata[g*32 +: 32];
  end

  logic [N_CH-1:0]   busy;
  logic [IW-1:0]     rr;
  logic [LEN_W-1:0]  ar_len_q;
  logic [1:0]        ar_size_q;
  logic              wr_active;
  logic [IW-1:0]     wr_id;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_size;
  logic [31:0]       wr_data;

  logic [N_CH-1:0]   elig, gnt, wr_owner, raw, r_hit, b_hit;
  logic [IW-1:0]     gnt_idx, rr_next;
  logic              gnt_vld, gnt_wr, b_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [LEN_W-1:0]  sel_len;
  logic [31:0]       sel_wdata;

  // B only counts once both AW and W have left; an early B is left unanswered.
  assign b_ok = ~rst & bvalid & wr_active & ~awvalid & ~wvalid & (bid == 4'(wr_id));

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    assign wr_owner[g] = wr_active & (wr_id == IW'(g));
    assign raw[g]      = wr_active & (wr_addr[ADDR_W-1:2] == req_addr[g][ADDR_W-1:2]);
    assign elig[g]     = ~rst & ch_req[g] & ~busy[g] &
                         (ch_wr[g] ? ~wr_active : (~arvalid & ~raw[g]));
    assign r_hit[g]    = ~rst & rvalid & (rid == 4'(g)) & busy[g] & ~wr_owner[g];
    assign b_hit[g]    = b_ok & wr_owner[g];
  end

  rr_arbiter #(.N(N_CH), .IW(IW)) u_arb (
    .elig    (elig),
    .rr      (rr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    sel_addr  = '0;
    sel_size  = '0;
    sel_len   = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt[i]) begin
        sel_addr  = req_addr[i];
        sel_size  = req_size[i];
        sel_len   = req_len[i];
        sel_wdata = req_wdata[i];
      end
    end
  end

  assign gnt_wr  = |(gnt & ch_wr);
  assign rr_next = (gnt_idx == IW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      rr        <= '0;
      arvalid   <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      wr_active <= 1'b0;
    end else begin
      busy <= (busy & ~((r_hit & {N_CH{rlast}}) | b_hit)) | gnt;
      if (arvalid && arready) arvalid <= 1'b0;
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready)   wvalid  <= 1'b0;
      if (b_ok)               wr_active <= 1'b0;
      if (gnt_vld) begin
        rr <= rr_next;
        if (gnt_wr) begin
          wr_active <= 1'b1;
          awvalid   <= 1'b1;
          wvalid    <= 1'b1;
          wr_id     <= gnt_idx;
          wr_addr   <= sel_addr;
          wr_size   <= sel_size;
          wr_data   <= sel_wdata;
        end else begin
          arvalid   <= 1'b1;
          arid      <= 4'(gnt_idx);
          araddr    <= sel_addr;
          ar_len_q  <= sel_len;
          ar_size_q <= sel_size;
        end
      end
    end
  end

  assign arlen   = 8'(ar_len_q);
  assign arsize  = {1'b0, ar_size_q};
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign rready  = 1'b1;

  assign awid    = 4'(wr_id);
  assign awaddr  = wr_addr;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, wr_size};
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign wid     = 4'(wr_id);
  assign wdata   = wr_data;
  assign wstrb   = wstrb_gen(wr_size, wr_addr[1:0]);
  assign wlast   = 1'b1;
  assign bready  = 1'b1;

  assign ch_addr_ok = gnt;
  assign ch_data_ok = r_hit | b_hit;
  assign ch_last    = (r_hit & {N_CH{rlast}}) | b_hit;
  assign ch_err     = (r_hit & {N_CH{rresp != RESP_OKAY}}) | (b_hit & {N_CH{bresp != RESP_OKAY}});
  assign ch_rdata   = rdata;

endmodule

// File: tb/tb_sram_axi_bridge_mc.sv
// Directed bench for sram_axi_bridge_mc: the bench plays both the SRAM masters and the AXI slave.
module tb_sram_axi_bridge_mc;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    ch_req, ch_wr, ch_addr_ok, ch_data_ok, ch_last, ch_err;
  logic [2*N-1:0]  ch_size;
  logic [LW*N-1:0] ch_len;
  logic [AW*N-1:0] ch_addr;
  logic [32*N-1:0] ch_wdata;
  logic [31:0]     ch_rdata;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [31:0] rdata, wdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_axi_bridge_mc #(.N_CH(N), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_len(ch_len),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_last(ch_last),
    .ch_err(ch_err), .ch_rdata(ch_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [1:0] size,
                         input logic [3:0] len, input logic [31:0] addr, input logic [31:0] d);
    ch_req[ch]          = 1'b1;
    ch_wr[ch]           = wr;
    ch_size[ch*2 +: 2]  = size;
    ch_len[ch*LW +: LW] = len;
    ch_addr[ch*AW +: AW] = addr;
    ch_wdata[ch*32 +: 32] = d;
  endtask

  task automatic clr_req(input int ch);
    ch_req[ch] = 1'b0;
  endtask

  task automatic ar_take(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    #1;
    while (!arvalid && n < 20) begin
      tick(); #1; n++;
    end
    chk("ar_valid", arvalid, 1);
    chk("ar_id", arid, id);
    chk("ar_addr", araddr, addr);
    chk("ar_len", arlen, len);
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic w_take();
    int n;
    n = 0;
    #1;
    while (!awvalid && n < 20) begin
      tick(); #1; n++;
    end
    chk("aw_valid", awvalid, 1);
    chk("w_valid", wvalid, 1);
    awready = 1'b1;
    wready  = 1'b1;
    tick();
    awready = 1'b0;
    wready  = 1'b0;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input logic last,
                        input logic [1:0] resp, input logic [1:0] e_ok,
                        input logic [1:0] e_last, input logic [1:0] e_err);
    rvalid = 1'b1; rid = id; rdata = d; rlast = last; rresp = resp;
    #1;
    chk("r_data_ok", ch_data_ok, e_ok);
    chk("r_last", ch_last, e_last);
    chk("r_err", ch_err, e_err);
    if (e_ok != 2'b00) chk("r_rdata", ch_rdata, d);
    tick();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ch_req = '0; ch_wr = '0; ch_size = '0; ch_len = '0; ch_addr = '0; ch_wdata = '0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    // Reset state, with a request pending that must not be acknowledged.
    set_req(0, 0, 2'd2, 4'd0, 32'hBFC0_0000, 32'h0);
    repeat (3) tick();
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_addr_ok", ch_addr_ok, 0);
    chk("rst_data_ok", ch_data_ok, 0);
    chk("rready", rready, 1);
    chk("bready", bready, 1);

    // 1: single-beat fetch on ch0, arready after two cycles.
    rst = 1'b0;
    #1;
    chk("t1_addr_ok", ch_addr_ok, 2'b01);
    tick();
    clr_req(0);
    #1;
    chk("t1_addr_ok_drop", ch_addr_ok, 2'b00);
    chk("t1_arvalid", arvalid, 1);
    chk("t1_arid", arid, 0);
    chk("t1_araddr", araddr, 32'hBFC0_0000);
    chk("t1_arlen", arlen, 0);
    chk("t1_arsize", arsize, 2);
    chk("t1_arburst", arburst, 2'b01);
    chk("t1_arlock", {arlock, arcache, arprot}, 0);
    tick(); tick();
    arready = 1'b1;
    #1;
    chk("t1_arvalid_hold", arvalid, 1);
    tick();
    arready = 1'b0;
    #1;
    chk("t1_arvalid_drop", arvalid, 0);
    r_beat(4'd0, 32'h3C1A_0000, 1'b1, 2'b00, 2'b01, 2'b01, 2'b00);
    #1;
    chk("t1_data_ok_drop", ch_data_ok, 0);

    // 2: ch1 eight-beat refill, then re-grant on the cycle after rlast.
    set_req(1, 0, 2'd2, 4'd7, 32'h0000_1000, 32'h0);
    #1;
    chk("t2_addr_ok", ch_addr_ok, 2'b10);
    tick();
    clr_req(1);
    #1;
    chk("t2_arburst", arburst, 2'b01);
    chk("t2_arsize", arsize, 2);
    ar_take(4'd1, 32'h0000_1000, 8'd7);
    for (int b = 0; b < 7; b++)
      r_beat(4'd1, 32'h1000_0000 + 32'(b), 1'b0, 2'b00, 2'b10, 2'b00, 2'b00);
    set_req(1, 0, 2'd2, 4'd0, 32'h0000_2000, 32'h0);
    #1;
    chk("t2_busy_block", ch_addr_ok, 2'b00);
    r_beat(4'd1, 32'h1000_0007, 1'b1, 2'b00, 2'b10, 2'b10, 2'b00);
    #1;
    chk("t2_regrant", ch_addr_ok, 2'b10);
    tick();
    clr_req(1);
    ar_take(4'd1, 32'h0000_2000, 8'd0);
    r_beat(4'd1, 32'h0000_0055, 1'b1, 2'b00, 2'b10, 2'b10, 2'b00);

    // 3: simultaneous reads after reset, interleaved return.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    set_req(0, 0, 2'd2, 4'd1, 32'h0000_0100, 32'h0);
    set_req(1, 0, 2'd2, 4'd1, 32'h0000_0200, 32'h0);
    #1;
    chk("t3_first", ch_addr_ok, 2'b01);
    tick();
    clr_req(0);
    #1;
    chk("t3_ar_block", ch_addr_ok, 2'b00);
    chk("t3_arid0", arid, 0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    #1;
    chk("t3_second", ch_addr_ok, 2'b10);
    tick();
    clr_req(1);
    ar_take(4'd1, 32'h0000_0200, 8'd1);
    r_beat(4'd1, 32'hA000_0001, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00);
    r_beat(4'd0, 32'hB000_0001, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00);
    r_beat(4'd1, 32'hA000_0002, 1'b1, 2'b00, 2'b10, 2'b10, 2'b00);
    r_beat(4'd0, 32'hB000_0002, 1'b1, 2'b00, 2'b01, 2'b01, 2'b00);

    // 4: byte write on ch1, W accepted before AW, early B ignored.
    set_req(1, 1, 2'd0, 4'd0, 32'h0000_0203, 32'hAB00_0000);
    #1;
    chk("t4_addr_ok", ch_addr_ok, 2'b10);
    tick();
    clr_req(1);
    wready = 1'b1;
    #1;
    chk("t4_awvalid", awvalid, 1);
    chk("t4_wvalid", wvalid, 1);
    chk("t4_wstrb", wstrb, 4'b1000);
    chk("t4_awaddr", awaddr, 32'h0000_0203);
    chk("t4_awlen", awlen, 0);
    chk("t4_awsize", awsize, 0);
    chk("t4_awburst", awburst, 2'b01);
    chk("t4_ids", {awid, wid}, 8'h11);
    chk("t4_wlast", wlast, 1);
    chk("t4_wdata", wdata, 32'hAB00_0000);
    tick();
    wready = 1'b0;
    #1;
    chk("t4_wvalid_drop", wvalid, 0);
    chk("t4_awvalid_hold", awvalid, 1);
    bvalid = 1'b1; bid = 4'd1;
    #1;
    chk("t4_early_b", ch_data_ok, 2'b00);
    tick();
    bvalid = 1'b0;
    tick();
    awready = 1'b1;
    #1;
    chk("t4_awvalid_late", awvalid, 1);
    tick();
    awready = 1'b0;
    #1;
    chk("t4_awvalid_drop", awvalid, 0);
    bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
    #1;
    chk("t4_b_data_ok", ch_data_ok, 2'b10);
    chk("t4_b_last", ch_last, 2'b10);
    chk("t4_b_err", ch_err, 2'b00);
    tick();
    bvalid = 1'b0;
    #1;
    chk("t4_b_pulse", ch_data_ok, 2'b00);

    // 5: read-after-write hazard on the same word, none on the next word.
    set_req(1, 1, 2'd2, 4'd0, 32'h0000_0204, 32'h1122_3344);
    #1;
    chk("t5_w_grant", ch_addr_ok, 2'b10);
    tick();
    clr_req(1);
    w_take();
    set_req(0, 0, 2'd2, 4'd0, 32'h0000_0206, 32'h0);
    #1;
    chk("t5_raw_block0", ch_addr_ok, 2'b00);
    tick();
    #1;
    chk("t5_raw_block1", ch_addr_ok, 2'b00);
    bvalid = 1'b1; bid = 4'd1;
    #1;
    chk("t5_b_data_ok", ch_data_ok, 2'b10);
    chk("t5_raw_block_b", ch_addr_ok, 2'b00);
    tick();
    bvalid = 1'b0;
    #1;
    chk("t5_raw_release", ch_addr_ok, 2'b01);
    tick();
    clr_req(0);
    ar_take(4'd0, 32'h0000_0206, 8'd0);
    r_beat(4'd0, 32'h0000_0206, 1'b1, 2'b00, 2'b01, 2'b01, 2'b00);
    set_req(1, 1, 2'd2, 4'd0, 32'h0000_0204, 32'h5555_AAAA);
    #1;
    chk("t5_w2_grant", ch_addr_ok, 2'b10);
    tick();
    clr_req(1);
    w_take();
    set_req(0, 0, 2'd2, 4'd0, 32'h0000_0208, 32'h0);
    #1;
    chk("t5_no_raw", ch_addr_ok, 2'b01);
    tick();
    clr_req(0);
    ar_take(4'd0, 32'h0000_0208, 8'd0);
    r_beat(4'd0, 32'h0000_0208, 1'b1, 2'b00, 2'b01, 2'b01, 2'b00);
    bvalid = 1'b1; bid = 4'd1;
    #1;
    chk("t5_b2_data_ok", ch_data_ok, 2'b10);
    tick();
    bvalid = 1'b0;

    // 6: error response, reset mid-burst, then normal operation resumes.
    set_req(0, 0, 2'd2, 4'd3, 32'h0000_0300, 32'h0);
    #1;
    chk("t6_addr_ok", ch_addr_ok, 2'b01);
    tick();
    clr_req(0);
    ar_take(4'd0, 32'h0000_0300, 8'd3);
    r_beat(4'd0, 32'hDEAD_0000, 1'b0, 2'b10, 2'b01, 2'b00, 2'b01);
    r_beat(4'd0, 32'hDEAD_0001, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00);
    rst = 1'b1;
    tick();
    #1;
    chk("t6_rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
    chk("t6_rst_data_ok", ch_data_ok, 2'b00);
    rst = 1'b0;
    r_beat(4'd0, 32'hDEAD_0002, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    r_beat(4'd3, 32'hDEAD_0003, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    set_req(0, 0, 2'd2, 4'd0, 32'h0000_0500, 32'h0);
    set_req(1, 0, 2'd2, 4'd0, 32'h0000_0600, 32'h0);
    #1;
    chk("t6_rr_reset", ch_addr_ok, 2'b01);
    tick();
    clr_req(0);
    ar_take(4'd0, 32'h0000_0500, 8'd0);
    #1;
    chk("t6_ch1_grant", ch_addr_ok, 2'b10);
    tick();
    clr_req(1);
    ar_take(4'd1, 32'h0000_0600, 8'd0);
    r_beat(4'd0, 32'h0000_0500, 1'b1, 2'b00, 2'b01, 2'b01, 2'b00);
    r_beat(4'd1, 32'h0000_0600, 1'b1, 2'b00, 2'b10, 2'b10, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
